// File: rtl/sc_dec_pkg.sv
// Shared types and helpers for the stochastic bitstream decoder.
//   dec_state_t : decoder FSM states (IDLE / ACC / DONE)
//   DATAWD_DEF  : default log2 window length
//   bip_map     : onesCnt -> bipolar two's complement 2*ones - N, with +N saturated to N-1
package sc_dec_pkg;

    localparam int unsigned DATAWD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } dec_state_t;

    // The result is taken from the low dw+1 bits by the caller. The only
    // unrepresentable value is +N, which is clamped to N-1.
    function automatic logic [31:0] bip_map(input logic [31:0] ones, input int unsigned dw);
        logic [31:0] n;
        n = 32'(1) << dw;
        if (ones == n) begin
            return n - 32'd1;
        end
        return (ones << 1) - n;
    endfunction

endpackage

// File: rtl/sc_win_cnt.sv
// Window bit counter: DATAWD-bit up counter with enable, sync clear and terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   i_en     : count one accepted bit
//   i_clr    : clear to zero (wins over i_en)
//   o_tc     : counter is at its all-ones terminal value
module sc_win_cnt #(
    parameter int unsigned DATAWD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    logic [DATAWD-1:0] r_cnt;

    // Counter wraps to zero naturally on the terminal accept.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + DATAWD'(1);
        end
    end

    assign o_tc = (r_cnt == {DATAWD{1'b1}});

endmodule

// File: rtl/sc_bs_dec.sv
// Stochastic bitstream decoder: counts ones over a window of 2^DATAWD accepted bits
// and returns the count as one result word through a valid/ready handshake.
//   clk, rst         : clock, synchronous active-high reset
//   iStart           : start a new window (also aborts a running one)
//   iBit, iBitVld    : stream bit and its valid
//   oBitRdy          : decoder accepts a bit this cycle
//   oVal, oVld, iRdy : result word, valid (held until accepted), downstream ready
//   oBusy            : window in progress
// Build option: SC_DEC_BIPOLAR_EN maps the result to 2*ones - N (saturated);
// otherwise the result is the unsigned ones count.
module sc_bs_dec
    import sc_dec_pkg::*;
#(
    parameter int unsigned DATAWD = DATAWD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iStart,
    input  logic              iBit,
    input  logic              iBitVld,
    output logic              oBitRdy,
    output logic [DATAWD:0]   oVal,
    output logic              oVld,
    input  logic              iRdy,
    output logic              oBusy
);

    localparam int unsigned VW = DATAWD + 1;

    dec_state_t    r_state;
    dec_state_t    w_nxt_state;
    logic [VW-1:0] r_ones;
    logic [VW-1:0] r_val;
    logic [VW-1:0] w_ones_inc;
    logic [VW-1:0] w_map;
    logic          w_accept;
    logic          w_tc;
    logic          w_clr;
    logic          w_en;
    logic          w_load;

    assign w_accept   = iBitVld && (r_state == ACC);
    assign w_ones_inc = r_ones + VW'(iBit);

    // Result mapping includes the bit accepted on the terminal cycle.
`ifdef SC_DEC_BIPOLAR_EN
    assign w_map = VW'(bip_map(32'(w_ones_inc), DATAWD));
`else
    assign w_map = w_ones_inc;
`endif

    sc_win_cnt #(
        .DATAWD (DATAWD)
    ) u_win_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_clr (w_clr),
        .o_tc  (w_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state and counter control.
    always_comb begin
        w_nxt_state = r_state;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_nxt_state = ACC;
                    w_clr       = 1'b1;
                end
            end
            ACC: begin
                // A restart discards the bit presented in the same cycle.
                if (iStart) begin
                    w_clr = 1'b1;
                end else if (w_accept) begin
                    w_en = 1'b1;
                    if (w_tc) begin
                        w_load      = 1'b1;
                        w_nxt_state = DONE;
                    end
                end
            end
            DONE: begin
                if (iRdy) begin
                    if (iStart) begin
                        w_nxt_state = ACC;
                        w_clr       = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // Ones counter; range 0..N fits in DATAWD+1 bits.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_ones <= '0;
        end else if (w_en) begin
            r_ones <= w_ones_inc;
        end
    end

    // Result word, held until the next terminal accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val <= '0;
        end else if (w_load) begin
            r_val <= w_map;
        end
    end

    assign oBitRdy = (r_state == ACC);
    assign oBusy   = (r_state == ACC);
    assign oVld    = (r_state == DONE);
    assign oVal    = r_val;

endmodule

// File: tb/tb_sc_bs_dec.sv
// Self-checking bench for sc_bs_dec (DATAWD=8, N=256) against a window-queue reference model.
module tb_sc_bs_dec;

    localparam int unsigned DW = 8;
    localparam int          N  = 256;

`ifdef SC_DEC_BIPOLAR_EN
    localparam int EXP_FULL  = 255;
    localparam int EXP_GAP   = 0;
    localparam int EXP_ABORT = 9'h100;
`else
    localparam int EXP_FULL  = 256;
    localparam int EXP_GAP   = 128;
    localparam int EXP_ABORT = 0;
`endif

    logic          clk = 1'b0;
    logic          d_rst = 1'b1;
    logic          d_start = 1'b0;
    logic          d_bit = 1'b0;
    logic          d_vld = 1'b0;
    logic          d_rdy = 1'b0;
    logic          oBitRdy;
    logic [DW:0]   oVal;
    logic          oVld;
    logic          oBusy;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a window is a queue of accepted bits; result when it reaches N.
    bit m_active = 0;
    bit m_have   = 0;
    int m_result = 0;
    bit m_win[$];

    always #5 clk = ~clk;

    sc_bs_dec #(.DATAWD(DW)) dut (
        .clk     (clk),
        .rst     (d_rst),
        .iStart  (d_start),
        .iBit    (d_bit),
        .iBitVld (d_vld),
        .oBitRdy (oBitRdy),
        .oVal    (oVal),
        .oVld    (oVld),
        .iRdy    (d_rdy),
        .oBusy   (oBusy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mdl_map(input int ones);
`ifdef SC_DEC_BIPOLAR_EN
        if (ones == N) return N - 1;
        return (2 * ones - N) & ((2 * N) - 1);
`else
        return ones;
`endif
    endfunction

    function automatic void mdl_step(input bit rst, input bit start, input bit b,
                                     input bit vld, input bit rdy);
        int ones;
        if (rst) begin
            m_active = 0;
            m_have   = 0;
            m_result = 0;
            m_win.delete();
        end else if (m_have) begin
            if (rdy) begin
                m_have = 0;
                if (start) begin
                    m_active = 1;
                    m_win.delete();
                end
            end
        end else if (m_active) begin
            if (start) begin
                m_win.delete();
            end else if (vld) begin
                m_win.push_back(b);
                if (m_win.size() == N) begin
                    ones = 0;
                    foreach (m_win[k]) ones += int'(m_win[k]);
                    m_result = mdl_map(ones);
                    m_active = 0;
                    m_have   = 1;
                end
            end
        end else if (start) begin
            m_active = 1;
            m_win.delete();
        end
    endfunction

    // One clock: inputs captured at the edge, outputs compared 1 time unit later.
    task automatic tick();
        bit s_rst, s_start, s_bit, s_vld, s_rdy;
        s_rst = d_rst; s_start = d_start; s_bit = d_bit; s_vld = d_vld; s_rdy = d_rdy;
        @(posedge clk);
        #1;
        mdl_step(s_rst, s_start, s_bit, s_vld, s_rdy);
        chk("bitrdy", 32'(oBitRdy), 32'(m_active));
        chk("busy",   32'(oBusy),   32'(m_active));
        chk("vld",    32'(oVld),    32'(m_have));
        chk("val",    32'(oVal),    32'(m_result));
    endtask

    task automatic idle_in();
        d_start = 1'b0; d_vld = 1'b0; d_bit = 1'b0;
    endtask

    initial begin : main
        int abit;
        int sz;
        int g;
        logic [DW:0] held;

        // Reset with random inputs.
        d_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d_start = 1'($urandom); d_bit = 1'($urandom);
            d_vld = 1'($urandom); d_rdy = 1'($urandom);
            tick();
        end
        chk("rst_vld", 32'(oVld), 0);
        chk("rst_rdy", 32'(oBitRdy), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_val", 32'(oVal), 0);
        d_rst = 1'b0; d_rdy = 1'b0; idle_in();
        tick();

        // Full window of ones, continuous valid.
        d_start = 1'b1; tick();
        d_start = 1'b0; d_vld = 1'b1; d_bit = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) chk("full_early_vld", 32'(oVld), 0);
            tick();
        end
        chk("full_vld", 32'(oVld), 1);
        chk("full_val", 32'(oVal), EXP_FULL);
        idle_in(); d_rdy = 1'b1; tick();
        chk("full_release", 32'(oVld), 0);
        d_rdy = 1'b0;

        // Gapped valids, alternating bits on accepted positions.
        d_start = 1'b1; tick();
        d_start = 1'b0; abit = 1; g = 0;
        while (!m_have && g < 1000) begin
            d_vld = ((g % 3) != 2);
            d_bit = 1'(abit);
            sz = m_win.size();
            tick();
            if (m_win.size() != sz) abit = 1 - abit;
            g++;
        end
        chk("gap_done", 32'(oVld), 1);
        chk("gap_val", 32'(oVal), EXP_GAP);

        // Backpressure: result held, bits and starts ignored.
        held = oVal;
        for (int i = 0; i < 10; i++) begin
            d_rdy = 1'b0; d_start = 1'($urandom);
            d_vld = 1'($urandom); d_bit = 1'($urandom);
            tick();
            chk("bp_stable", 32'(oVal), 32'(held));
            chk("bp_bitrdy", 32'(oBitRdy), 0);
        end
        d_rdy = 1'b1; d_start = 1'b1; d_vld = 1'b0; tick();
        chk("b2b_vld", 32'(oVld), 0);
        chk("b2b_busy", 32'(oBusy), 1);
        d_rdy = 1'b0;

        // Abort: 100 ones, restart (bit discarded), then 256 zeros.
        d_start = 1'b0; d_vld = 1'b1; d_bit = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        d_start = 1'b1; tick();
        chk("abort_busy", 32'(oBusy), 1);
        d_start = 1'b0; d_bit = 1'b0;
        for (int i = 0; i < N; i++) tick();
        chk("abort_vld", 32'(oVld), 1);
        chk("abort_val", 32'(oVal), EXP_ABORT);
        idle_in(); d_rdy = 1'b1; tick();
        d_rdy = 1'b0;

        // Mid-window reset after 50 accepts.
        d_start = 1'b1; tick();
        d_start = 1'b0; d_vld = 1'b1; d_bit = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        d_rst = 1'b1; tick();
        chk("mr_busy", 32'(oBusy), 0);
        chk("mr_val", 32'(oVal), 0);
        d_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            d_vld = 1'($urandom); d_bit = 1'($urandom);
            tick();
        end
        chk("mr_no_vld", 32'(oVld), 0);
        d_start = 1'b1; tick();
        d_start = 1'b0; g = 0;
        while (!m_have && g < 1000) begin
            d_vld = ($urandom_range(3) != 0); d_bit = 1'($urandom);
            tick();
            g++;
        end
        chk("mr_done", 32'(oVld), 1);
        idle_in(); d_rdy = 1'b1; tick();

        // Random traffic with occasional resets and restarts.
        for (int i = 0; i < 4000; i++) begin
            d_rst   = ($urandom_range(599) == 0);
            d_start = ($urandom_range(149) == 0);
            d_vld   = 1'($urandom);
            d_bit   = ($urandom_range(3) != 0);
            d_rdy   = ($urandom_range(3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
